down_count_timer: RTL and testbench
===================================

# down_count_timer

Synchronous, parameterized down counter with a loadable reload value, count enable, one-shot and periodic modes, and a registered terminal-count pulse. It is the count-down counterpart of the team's ripple up counter. Control logic uses it as a programmable interval or delay timer. All flops are clocked by `clk` only; there is no ripple clocking.

## Interface

Parameters:
- `WIDTH`, default 4: counter and reload width in bits; must be ≥ 2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `load` in 1: for one cycle, captures `load_val` into both the reload register and the counter.
- `load_val` in WIDTH: value sampled when `load`=1.
- `start` in 1: begins or restarts counting; see Operation.
- `en` in 1: count enable; sampled only in RUN.
- `mode` in 1: 0 = one-shot, 1 = periodic; sampled at every terminal event.
- `count` out WIDTH: current counter register.
- `busy` out 1: high while state = RUN. Decoded combinationally from the state register.
- `tc` out 1: registered one-cycle terminal-count pulse.
- `done` out 1: high while state = DONE.

## Operation

- States: IDLE, RUN, DONE; encoding is free.
- Reset (`rst`=0, asynchronous):
  - state = IDLE, `count` = all ones (4'hF for WIDTH=4), reload register = all ones.
  - `tc` = 0, `done` = 0, `busy` = 0.
- Priority at each edge: `load` > `start` > counting.
- `load`=1, in any state:
  - reload register and `count` ← `load_val`; state → IDLE; `tc` ← 0.
  - `start` and `en` are ignored that cycle.
- `start`=1 (no `load`):
  - IDLE → RUN; `count` is unchanged.
  - DONE → RUN; `count` ← reload.
  - In RUN, `start` is ignored.
- RUN with `en`=0: `count` holds; `tc` ← 0.
- RUN with `en`=1 and `count` ≠ 0: `count` ← `count` − 1 (modulo 2^WIDTH is never reached); `tc` ← 0.
- RUN with `en`=1 and `count` = 0 (the terminal event): `tc` ← 1, then:
  - `mode`=1 (periodic): `count` ← reload; stay in RUN.
  - `mode`=0 (one-shot): `count` stays 0; state → DONE.
- In all other cases `tc` ← 0, so `tc` is never high for two consecutive cycles unless the terminal event repeats.
- `en` is ignored in IDLE and DONE; `count` holds there.
- Reload value 0 in periodic mode gives a terminal event on every enabled cycle, so `tc` stays high continuously while `en`=1.
- `mode` may change at any time; only its value at a terminal event matters.

## Timing

- Period: reload value R gives exactly R+1 enabled cycles from entering RUN (with `count`=R) to the terminal edge.
- `tc` latency: `tc` is high in the cycle immediately after the terminal edge.
- One-shot: `done` rises and `busy` falls in that same cycle.
- `en` gaps stretch the period by exactly the number of disabled RUN cycles.
- Asynchronous reset mid-RUN clears everything immediately. The first edge after reset release with `start`=1 enters RUN from `count` = all ones, giving 2^WIDTH enabled cycles to `tc`.
- `load` and the terminal event on the same edge: `load` wins. `tc` = 0 next cycle, state = IDLE.

## Test plan

- Reset: assert `rst`=0 mid-run → `count`=4'hF, `busy`=0, `done`=0 and `tc`=0 immediately, without waiting for a clock edge.
- One-shot, R=3, `en`=1: `load` then `start` → `count` sequence 3, 2, 1, 0 → on the 4th edge after `start`, `tc`=1 for one cycle, `done`=1, `busy`=0, `count` holds 0.
- Periodic, R=2, `en`=1 for 12 cycles → `tc` pulses every 3rd cycle, 4 pulses total; `count` sequence 2, 1, 0, 2, 1, 0, …
- Enable gating, R=3, one-shot: deassert `en` for 2 cycles while `count`=1 → `count` holds 1, and `tc` arrives 2 cycles later than the ungated case.
- Restart from DONE: `start` → `count`=3 and RUN again. Also: `load` 4'h5 during RUN at `count`=0 with `en`=1 → no `tc`, state IDLE, `count`=5.
- Periodic with R=0 and `en`=1 for 4 cycles → `tc`=1 on all 4 cycles; `count` stays 0.

Source files
------------

// File: rtl/down_count_timer_if.sv
// Control/status bundle for down_count_timer.
//   master : drives load, load_val, start, en, mode; observes count, busy, tc, done
//   slave  : the timer itself (consumes controls, produces status)
interface down_count_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output load, load_val, start, en, mode,
        input  count, busy, tc, done
    );

    modport slave (
        input  load, load_val, start, en, mode,
        output count, busy, tc, done
    );
endinterface

// File: rtl/down_count_timer.sv
// Programmable interval/delay timer: down counter with a reload register,
// count enable, one-shot (mode=0) and periodic (mode=1) operation and a
// registered one-cycle terminal-count pulse.
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-low reset
//   bus.load   : capture load_val into reload register and counter, go IDLE
//   bus.start  : IDLE -> RUN (count kept), DONE -> RUN (count <= reload)
//   bus.en     : count enable, only meaningful in RUN
//   bus.mode   : 0 one-shot, 1 periodic; looked at on the terminal event
//   bus.count  : counter register
//   bus.busy   : state is RUN
//   bus.tc     : registered terminal-count pulse
//   bus.done   : state is DONE
module down_count_timer #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    down_count_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            count_reg  <= '1;
            reload_reg <= '1;
            tc_reg     <= 1'b0;
        end else begin
            // tc is a pulse: only the terminal-event branch raises it.
            tc_reg <= 1'b0;
            if (bus.load) begin
                reload_reg <= bus.load_val;
                count_reg  <= bus.load_val;
                state_reg  <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            state_reg <= RUN;
                        end
                    end
                    DONE: begin
                        if (bus.start) begin
                            state_reg <= RUN;
                            count_reg <= reload_reg;
                        end
                    end
                    RUN: begin
                        if (bus.en) begin
                            if (count_reg != '0) begin
                                count_reg <= count_reg - WIDTH'(1);
                            end else begin
                                // Terminal event: count reached zero while enabled.
                                tc_reg <= 1'b1;
                                if (bus.mode) begin
                                    count_reg <= reload_reg;
                                end else begin
                                    state_reg <= DONE;
                                end
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count = count_reg;
    assign bus.busy  = (state_reg == RUN);
    assign bus.done  = (state_reg == DONE);
    assign bus.tc    = tc_reg;

endmodule

// File: tb/tb_down_count_timer.sv
module tb_down_count_timer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    down_count_timer_if #(.WIDTH(W)) bus ();

    down_count_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = running, 2 = finished.
    int   m_phase  = 0;
    int   m_count  = (1 << W) - 1;
    int   m_reload = (1 << W) - 1;
    int   m_tc     = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase  <= 0;
            m_count  <= (1 << W) - 1;
            m_reload <= (1 << W) - 1;
            m_tc     <= 0;
        end else if (bus.load) begin
            m_reload <= int'(bus.load_val);
            m_count  <= int'(bus.load_val);
            m_phase  <= 0;
            m_tc     <= 0;
        end else if (bus.start && m_phase != 1) begin
            if (m_phase == 2) m_count <= m_reload;
            m_phase <= 1;
            m_tc    <= 0;
        end else if (m_phase == 1 && bus.en && m_count == 0) begin
            m_tc <= 1;
            if (bus.mode) m_count <= m_reload;
            else          m_phase <= 2;
        end else if (m_phase == 1 && bus.en) begin
            m_count <= m_count - 1;
            m_tc    <= 0;
        end else begin
            m_tc <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("model_count", int'(bus.count), m_count);
            chk("model_busy",  int'(bus.busy),  int'(m_phase == 1));
            chk("model_done",  int'(bus.done),  int'(m_phase == 2));
            chk("model_tc",    int'(bus.tc),    m_tc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d load=%0b val=%0d start=%0b en=%0b mode=%0b -> count=%0d busy=%0b tc=%0b done=%0b",
                 cyc, bus.load, bus.load_val, bus.start, bus.en, bus.mode,
                 bus.count, bus.busy, bus.tc, bus.done);
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1; bus.load_val = W'(v);
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    int pulses;

    initial begin
        bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0;
        #2 rst = 1'b0;
        checking = 1'b1;
        #1;
        chk("reset_count", int'(bus.count), 15);
        chk("reset_busy",  int'(bus.busy), 0);
        chk("reset_done",  int'(bus.done), 0);
        chk("reset_tc",    int'(bus.tc), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // From reset value all ones: 16 enabled cycles to tc.
        bus.en = 1'b1;
        do_start();
        chk("fromrst_busy", int'(bus.busy), 1);
        chk("fromrst_count", int'(bus.count), 15);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("fromrst_down", int'(bus.count), 15 - i);
            chk("fromrst_notc", int'(bus.tc), 0);
        end
        step();
        chk("fromrst_tc", int'(bus.tc), 1);
        chk("fromrst_done", int'(bus.done), 1);
        step();
        chk("fromrst_tc_drop", int'(bus.tc), 0);

        // One-shot R=3.
        do_load(3);
        chk("os_load_count", int'(bus.count), 3);
        chk("os_load_idle", int'(bus.busy), 0);
        do_start();
        chk("os_start_count", int'(bus.count), 3);
        step(); chk("os_c2", int'(bus.count), 2);
        step(); chk("os_c1", int'(bus.count), 1);
        step(); chk("os_c0", int'(bus.count), 0); chk("os_notc", int'(bus.tc), 0);
        step();
        chk("os_tc", int'(bus.tc), 1);
        chk("os_done", int'(bus.done), 1);
        chk("os_busy", int'(bus.busy), 0);
        chk("os_hold0", int'(bus.count), 0);
        step();
        chk("os_tc_once", int'(bus.tc), 0);
        chk("os_still_done", int'(bus.done), 1);

        // Restart from DONE, then en gap of 2 cycles at count=1.
        do_start();
        chk("restart_count", int'(bus.count), 3);
        chk("restart_busy", int'(bus.busy), 1);
        step(); step();
        chk("gap_at1", int'(bus.count), 1);
        bus.en = 1'b0;
        step(); chk("gap_hold_a", int'(bus.count), 1);
        step(); chk("gap_hold_b", int'(bus.count), 1);
        bus.en = 1'b1;
        step(); chk("gap_c0", int'(bus.count), 0); chk("gap_notc", int'(bus.tc), 0);
        step(); chk("gap_tc_edge6", int'(bus.tc), 1);

        // Periodic R=2, 12 enabled cycles -> 4 pulses.
        bus.mode = 1'b1;
        do_load(2);
        bus.en = 1'b0;
        do_start();
        bus.en = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("per_count", int'(bus.count), (((2 - k) % 3) + 3) % 3);
            chk("per_tc", int'(bus.tc), int'(k % 3 == 0));
            if (bus.tc) pulses++;
        end
        chk("per_pulses", pulses, 4);

        // Load wins over a terminal event.
        step(); step();
        chk("ldwin_c0", int'(bus.count), 0);
        bus.load = 1'b1; bus.load_val = 4'h5;
        step();
        bus.load = 1'b0;
        chk("ldwin_tc", int'(bus.tc), 0);
        chk("ldwin_busy", int'(bus.busy), 0);
        chk("ldwin_count", int'(bus.count), 5);

        // Periodic R=0: tc every enabled cycle.
        do_load(0);
        do_start();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("r0_tc", int'(bus.tc), 1);
            chk("r0_count", int'(bus.count), 0);
        end

        // Asynchronous reset in the middle of a run, with tc high.
        #3 rst = 1'b0;
        #1;
        chk("async_count", int'(bus.count), 15);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_done", int'(bus.done), 0);
        chk("async_tc", int'(bus.tc), 0);
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete (errors=%0d)", errors);
        $fatal(1);
    end

endmodule
